regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised multi-register file, the next-generation register file for the simple processor datapath. It provides one synchronous write port and two combinational read ports, with:
- selectable width and depth;
- write enable and asynchronous clear;
- optional hard-wired zero register;
- optional write-to-read bypass;
- a per-register busy scoreboard, so decode can detect operands still pending from multi-cycle units.

It sits between decode (read addresses, reservations) and writeback (write port).

Parameters:
DATA_W, 8, data width of each register
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 always reads 0; writes and reservations to it are ignored
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads show the stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve strobe: mark rsv_addr busy
rsv_addr  in  ADDR_W  register to reserve
rd1_addr  in  ADDR_W  read port 1 address
rd1_data  out  DATA_W  read port 1 data
rd1_busy  out  1  read port 1 operand pending
rd2_addr  in  ADDR_W  read port 2 address
rd2_data  out  DATA_W  read port 2 data
rd2_busy  out  1  read port 2 operand pending
busy_vec  out  DEPTH  registered busy bit per register
any_busy  out  1  OR of busy_vec

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-reservation):
  - all registers cleared to 0; busy_vec cleared to 0.
  - Outputs then: rdX_data = 0 (or bypass value, see below), rdX_busy = 0, any_busy = 0.
  - Reset has priority over every strobe.
- Write: on a rising clk with wr_en = 1, reg[wr_addr] <= wr_data. Latency is 1 cycle to the stored value. With wr_en = 0 the contents hold.
- Write and busy:
  - a write also clears busy[wr_addr] (writeback completes the pending op);
  - a write to a non-busy register is legal and leaves it non-busy.
- Reserve: on a rising clk with rsv_en = 1, busy[rsv_addr] <= 1.
- Same-cycle write and reserve:
  - same address: reserve wins; data is written and busy ends at 1 (a new producer is issued);
  - different addresses: both take effect independently.
- Reserving an already-busy register keeps it busy. There is no count; a single write clears it.
- Reads are combinational from address to data, with zero cycles of latency.
- With BYPASS=1 and wr_en=1 and wr_addr==rdX_addr:
  - rdX_data = wr_data;
  - rdX_busy = 0, unless rsv_en=1 and rsv_addr==rdX_addr, in which case rdX_busy = 1.
- Otherwise rdX_data = reg[rdX_addr] and rdX_busy = busy[rdX_addr].
- Both read ports may use the same address and return identical values.
- With ZERO_REG=1, address 0 behaves as follows:
  - rdX_data = 0 and rdX_busy = 0 always, bypass included;
  - writes and reservations to it have no effect;
  - busy_vec[0] is held at 0.
- Reset with BYPASS=1: during reset rdX_data shows the bypass value if wr_en is asserted. The bench drives wr_en = 0 during reset.
- busy_vec and any_busy are registered-state only; no bypass applies to them.
- No storage state uses negedge clk. No simulation delays and no $display in synthesised RTL.

Test Plan:
- Reset: write 8'hA5 to reg5, reserve reg3, then pulse rst_n low mid-cycle -> immediately rd1(addr5)=0, busy_vec=0, any_busy=0, without waiting for a clk edge.
- Basic write/read: write reg1=2 and reg2=7 in consecutive cycles, wr_en=0 after -> rd1(addr1)=2, rd2(addr2)=7; both values held over 10 idle cycles.
- Bypass:
  - BYPASS=1, reg4=9, wr_en=1 wr_addr=4 wr_data=8'h3C, rd1_addr=4 -> rd1_data=8'h3C in the same cycle, reg4=8'h3C after the edge;
  - BYPASS=0 with the same stimulus -> rd1_data=9 until the edge.
- Scoreboard:
  - reserve reg6 -> next cycle busy_vec[6]=1, rd2_busy(addr6)=1, any_busy=1;
  - write reg6=8'h11 -> same cycle rd2_busy=0, rd2_data=8'h11 (BYPASS=1); after the edge busy_vec=0.
- Simultaneous reserve and write:
  - rsv and wr both to reg2 -> after the edge reg2=wr_data and busy_vec[2]=1;
  - rsv reg2 with wr reg3 -> busy_vec[2]=1 and reg3 written.
- ZERO_REG=1: write reg0=8'hFF and reserve reg0 -> rd1(addr0)=0, rd1_busy=0, busy_vec[0]=0; reg1..7 unaffected.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register-file bus: one write port, one reserve port, two read ports and
// the busy scoreboard outputs.
//   master : the decode/writeback side; drives the addresses, strobes and write data
//   slave  : the register file; returns read data/busy, busy_vec and any_busy
interface regfile_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_busy;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd2_data;
    logic              rd2_busy;
    logic [DEPTH-1:0]  busy_vec;
    logic              any_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd1_addr, rd2_addr,
        input  rd1_data, rd1_busy, rd2_data, rd2_busy, busy_vec, any_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd1_addr, rd2_addr,
        output rd1_data, rd1_busy, rd2_data, rd2_busy, busy_vec, any_busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with a busy scoreboard.
// One synchronous write port, two combinational read ports, and a reserve
// port that marks a register as pending until its next write.
// Ports:
//   clk   - rising-edge clock for all state
//   rst_n - asynchronous active-low clear of all registers and busy bits
//   bus   - regfile_param_if.slave (write, reserve, read ports, busy_vec, any_busy)
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic            clk,
    input logic            rst_n,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;

    // Register 0 ignores writes and reservations when hard-wired to zero.
    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    // Reserve is applied after the write-clear so a same-address pair
    // leaves the register busy (a new producer was issued).
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)  busy_nxt[bus.wr_addr]  = 1'b0;
        if (rsv_ok) busy_nxt[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
            busy <= busy_nxt;
        end
    end

    logic [DATA_W-1:0] rd1_d, rd2_d;
    logic              rd1_b, rd2_b;

    always_comb begin
        rd1_d = mem[bus.rd1_addr];
        rd1_b = busy[bus.rd1_addr];
        rd2_d = mem[bus.rd2_addr];
        rd2_b = busy[bus.rd2_addr];
        if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd1_addr)) begin
            rd1_d = bus.wr_data;
            rd1_b = bus.rsv_en && (bus.rsv_addr == bus.rd1_addr);
        end
        if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd2_addr)) begin
            rd2_d = bus.wr_data;
            rd2_b = bus.rsv_en && (bus.rsv_addr == bus.rd2_addr);
        end
        // Zero register overrides the bypass path as well.
        if ((ZERO_REG != 0) && (bus.rd1_addr == '0)) begin
            rd1_d = '0;
            rd1_b = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.rd2_addr == '0)) begin
            rd2_d = '0;
            rd2_b = 1'b0;
        end
    end

    assign bus.rd1_data = rd1_d;
    assign bus.rd1_busy = rd1_b;
    assign bus.rd2_data = rd2_d;
    assign bus.rd2_busy = rd2_b;
    assign bus.busy_vec = busy;
    assign bus.any_busy = |busy;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param. Three instances cover
// (ZERO_REG,BYPASS) = (0,1), (0,0), (1,1); all share the same stimulus.
module tb_regfile_param;
    logic       clk;
    logic       rst_n;
    logic       wr_en, rsv_en;
    logic [2:0] wr_addr, rsv_addr, rd1_addr, rd2_addr;
    logic [7:0] wr_data;

    int n_pass  = 0;
    int n_total = 0;
    bit run_cmp = 0;

    regfile_param_if #(.DATA_W(8), .ADDR_W(3)) if_a ();
    regfile_param_if #(.DATA_W(8), .ADDR_W(3)) if_b ();
    regfile_param_if #(.DATA_W(8), .ADDR_W(3)) if_c ();

    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
    assign if_a.rsv_en = rsv_en; assign if_b.rsv_en = rsv_en; assign if_c.rsv_en = rsv_en;
    assign if_a.rsv_addr = rsv_addr; assign if_b.rsv_addr = rsv_addr; assign if_c.rsv_addr = rsv_addr;
    assign if_a.rd1_addr = rd1_addr; assign if_b.rd1_addr = rd1_addr; assign if_c.rd1_addr = rd1_addr;
    assign if_a.rd2_addr = rd2_addr; assign if_b.rd2_addr = rd2_addr; assign if_c.rd2_addr = rd2_addr;

    // Gathered outputs, indexed by configuration
    logic [7:0] o_rd1d [3];
    logic [7:0] o_rd2d [3];
    logic       o_rd1b [3];
    logic       o_rd2b [3];
    logic [7:0] o_bv   [3];
    logic       o_any  [3];
    assign o_rd1d[0] = if_a.rd1_data; assign o_rd1d[1] = if_b.rd1_data; assign o_rd1d[2] = if_c.rd1_data;
    assign o_rd2d[0] = if_a.rd2_data; assign o_rd2d[1] = if_b.rd2_data; assign o_rd2d[2] = if_c.rd2_data;
    assign o_rd1b[0] = if_a.rd1_busy; assign o_rd1b[1] = if_b.rd1_busy; assign o_rd1b[2] = if_c.rd1_busy;
    assign o_rd2b[0] = if_a.rd2_busy; assign o_rd2b[1] = if_b.rd2_busy; assign o_rd2b[2] = if_c.rd2_busy;
    assign o_bv[0]   = if_a.busy_vec; assign o_bv[1]   = if_b.busy_vec; assign o_bv[2]   = if_c.busy_vec;
    assign o_any[0]  = if_a.any_busy; assign o_any[1]  = if_b.any_busy; assign o_any[2]  = if_c.any_busy;

    // Reference model: per-configuration register contents and pending set
    bit         zr [3] = '{0, 0, 1};
    bit         bp [3] = '{1, 0, 1};
    logic [7:0] m_mem [3][8];
    bit         m_bsy [3][8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 8; r++) begin
                    m_mem[c][r] = 8'h00;
                    m_bsy[c][r] = 0;
                end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (wr_en && !(zr[c] && wr_addr == 3'd0)) begin
                    m_mem[c][wr_addr] = wr_data;
                    m_bsy[c][wr_addr] = 0;
                end
                if (rsv_en && !(zr[c] && rsv_addr == 3'd0))
                    m_bsy[c][rsv_addr] = 1;
            end
        end
    end

    task automatic exp_rd(input int c, input logic [2:0] a, output logic [7:0] d, output logic b);
        if (zr[c] && a == 3'd0) begin
            d = 8'h00; b = 1'b0;
        end else if (bp[c] && wr_en && wr_addr == a) begin
            d = wr_data; b = rsv_en && (rsv_addr == a);
        end else begin
            d = m_mem[c][a]; b = m_bsy[c][a];
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (run_cmp) begin
            for (int c = 0; c < 3; c++) begin
                logic [7:0] d1, d2, bv;
                logic       b1, b2;
                exp_rd(c, rd1_addr, d1, b1);
                exp_rd(c, rd2_addr, d2, b2);
                bv = '0;
                for (int r = 0; r < 8; r++) bv[r] = m_bsy[c][r];
                check($sformatf("cfg%0d rd1_data", c), {24'h0, o_rd1d[c]}, {24'h0, d1});
                check($sformatf("cfg%0d rd1_busy", c), {31'h0, o_rd1b[c]}, {31'h0, b1});
                check($sformatf("cfg%0d rd2_data", c), {24'h0, o_rd2d[c]}, {24'h0, d2});
                check($sformatf("cfg%0d rd2_busy", c), {31'h0, o_rd2b[c]}, {31'h0, b2});
                check($sformatf("cfg%0d busy_vec", c), {24'h0, o_bv[c]}, {24'h0, bv});
                check($sformatf("cfg%0d any_busy", c), {31'h0, o_any[c]}, {31'h0, (bv != 8'h00)});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; rsv_en = 0;
    endtask

    initial begin
        rst_n = 0; wr_en = 0; rsv_en = 0;
        wr_addr = 0; wr_data = 0; rsv_addr = 0; rd1_addr = 0; rd2_addr = 0;
        step(); step();
        rst_n = 1;
        run_cmp = 1;
        #1;
        check("init rd1_data", {24'h0, if_a.rd1_data}, 32'h0);
        check("init any_busy", {31'h0, if_a.any_busy}, 32'h0);

        // Asynchronous reset mid-cycle
        wr_en = 1; wr_addr = 3'd5; wr_data = 8'hA5;
        step();
        wr_en = 0; rsv_en = 1; rsv_addr = 3'd3;
        step();
        rsv_en = 0; rd1_addr = 3'd5;
        #1;
        check("pre-rst rd1_data", {24'h0, if_a.rd1_data}, 32'hA5);
        check("pre-rst busy_vec", {24'h0, if_a.busy_vec}, 32'h08);
        rst_n = 0;
        #1;
        check("rst rd1_data a", {24'h0, if_a.rd1_data}, 32'h0);
        check("rst busy_vec a", {24'h0, if_a.busy_vec}, 32'h0);
        check("rst any_busy a", {31'h0, if_a.any_busy}, 32'h0);
        check("rst rd1_data b", {24'h0, if_b.rd1_data}, 32'h0);
        step();
        rst_n = 1;

        // Basic write/read and hold
        wr_en = 1; wr_addr = 3'd1; wr_data = 8'd2;
        step();
        wr_addr = 3'd2; wr_data = 8'd7;
        step();
        idle_inputs(); rd1_addr = 3'd1; rd2_addr = 3'd2;
        #1;
        check("basic rd1", {24'h0, if_a.rd1_data}, 32'd2);
        check("basic rd2", {24'h0, if_a.rd2_data}, 32'd7);
        repeat (10) step();
        check("hold rd1", {24'h0, if_b.rd1_data}, 32'd2);
        check("hold rd2", {24'h0, if_b.rd2_data}, 32'd7);

        // Bypass vs. no bypass
        wr_en = 1; wr_addr = 3'd4; wr_data = 8'd9;
        step();
        wr_data = 8'h3C; rd1_addr = 3'd4;
        #1;
        check("bypass rd1 a", {24'h0, if_a.rd1_data}, 32'h3C);
        check("nobypass rd1 b", {24'h0, if_b.rd1_data}, 32'd9);
        step();
        idle_inputs();
        #1;
        check("post-edge rd1 a", {24'h0, if_a.rd1_data}, 32'h3C);
        check("post-edge rd1 b", {24'h0, if_b.rd1_data}, 32'h3C);

        // Scoreboard reserve then writeback
        rsv_en = 1; rsv_addr = 3'd6; rd2_addr = 3'd6;
        step();
        rsv_en = 0;
        #1;
        check("rsv busy_vec[6]", {31'h0, if_a.busy_vec[6]}, 32'h1);
        check("rsv rd2_busy", {31'h0, if_a.rd2_busy}, 32'h1);
        check("rsv any_busy", {31'h0, if_a.any_busy}, 32'h1);
        wr_en = 1; wr_addr = 3'd6; wr_data = 8'h11;
        #1;
        check("wb rd2_busy a", {31'h0, if_a.rd2_busy}, 32'h0);
        check("wb rd2_data a", {24'h0, if_a.rd2_data}, 32'h11);
        check("wb rd2_busy b", {31'h0, if_b.rd2_busy}, 32'h1);
        step();
        idle_inputs();
        #1;
        check("wb busy_vec", {24'h0, if_a.busy_vec}, 32'h0);

        // Same-cycle reserve and write
        wr_en = 1; wr_addr = 3'd2; wr_data = 8'h55;
        rsv_en = 1; rsv_addr = 3'd2; rd1_addr = 3'd2;
        step();
        idle_inputs();
        #1;
        check("same rd1_data", {24'h0, if_a.rd1_data}, 32'h55);
        check("same busy_vec[2]", {31'h0, if_a.busy_vec[2]}, 32'h1);
        wr_en = 1; wr_addr = 3'd3; wr_data = 8'h66;
        rsv_en = 1; rsv_addr = 3'd2; rd2_addr = 3'd3;
        step();
        idle_inputs();
        #1;
        check("diff busy_vec", {24'h0, if_a.busy_vec}, 32'h04);
        check("diff rd2_data", {24'h0, if_a.rd2_data}, 32'h66);

        // Hard-wired zero register
        wr_en = 1; wr_addr = 3'd0; wr_data = 8'hFF;
        rsv_en = 1; rsv_addr = 3'd0; rd1_addr = 3'd0;
        #1;
        check("zero bypass rd1 c", {24'h0, if_c.rd1_data}, 32'h0);
        check("zero bypass busy c", {31'h0, if_c.rd1_busy}, 32'h0);
        check("nozero bypass rd1 a", {24'h0, if_a.rd1_data}, 32'hFF);
        step();
        idle_inputs(); rd2_addr = 3'd1;
        #1;
        check("zero rd1 c", {24'h0, if_c.rd1_data}, 32'h0);
        check("zero rd1_busy c", {31'h0, if_c.rd1_busy}, 32'h0);
        check("zero busy_vec c", {24'h0, if_c.busy_vec}, 32'h04);
        check("zero reg1 c", {24'h0, if_c.rd2_data}, 32'd2);
        check("nozero rd1 a", {24'h0, if_a.rd1_data}, 32'hFF);
        check("nozero busy_vec[0] a", {31'h0, if_a.busy_vec[0]}, 32'h1);

        // Randomized traffic checked by the per-cycle compare process
        for (int i = 0; i < 400; i++) begin
            step();
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 3'($urandom_range(0, 7));
            rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rd2_addr = ($urandom_range(0, 3) == 0) ? rd1_addr : 3'($urandom_range(0, 7));
        end
        step();
        idle_inputs();
        step(); step();
        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
